// File: rtl/memory_stage_if.sv
// Data-memory request/ready bus between memory_stage (master) and the data memory (slave).
interface memory_stage_if #(
    parameter int unsigned WORD_W = 32
);
    logic              dmem_req;
    logic              dmem_wen;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [3:0]        dmem_strb;
    logic              dmem_ready;
    logic [WORD_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_wen, dmem_addr, dmem_wdata, dmem_strb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_wen, dmem_addr, dmem_wdata, dmem_strb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// EX/MEM consumer: data-memory handshake, branch resolution/redirect, MEM/WB register, sticky halt.
// Optional MEM_MISALIGN_CHECK_EN adds the misaligned output and suppresses misaligned half/word accesses.
module memory_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] em_pc,
    input  logic              em_halt,
    input  logic [REG_W-1:0]  em_rd,
    input  logic              em_dread,
    input  logic [1:0]        em_dwrite,
    input  logic [1:0]        em_reg_wr_src,
    input  logic              em_branch_pol,
    input  logic [1:0]        em_pc_ctrl,
    input  logic [WORD_W-1:0] em_rdat2,
    input  logic [WORD_W-1:0] em_alu_out,
    input  logic              em_alu_zero,
    input  logic [WORD_W-1:0] em_pc_plus_imm,
    input  logic              em_branch_predict,
    input  logic [WORD_W-1:0] em_branch_target,
    input  logic              mem_flush,
    memory_stage_if.master    dmem,
    output logic              mem_stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              bp_update,
    output logic              bp_taken,
    output logic [WORD_W-1:0] bp_target,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [WORD_W-1:0] wb_data,
    output logic              halt
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  reg_t;
    typedef enum logic { IDLE, WAIT } state_e;

    state_e state_q, state_d;
    logic   halt_q, halt_d;
    logic   flush_q, flush_d;
    logic   wb_valid_q, wb_valid_d;
    reg_t   wb_rd_q;
    word_t  wb_data_q, wb_data_d;

    logic   mem_op, misalign_hit, req, stall, kill, taken, mispredict, resolve_en;
    logic [1:0] lane;
    word_t  target, pc_plus4;

    assign mem_op = em_dread | (em_dwrite != 2'd0);
    assign lane   = em_alu_out[1:0];
    assign kill   = mem_flush | flush_q;

`ifdef MEM_MISALIGN_CHECK_EN
    logic is_half, is_word;
    assign is_half      = (em_dwrite == 2'd2);
    assign is_word      = (em_dwrite == 2'd3) | ((em_dwrite == 2'd0) & em_dread);
    assign misalign_hit = ~halt_q & (state_q == IDLE) & mem_op &
                          ((is_half & em_alu_out[0]) | (is_word & (lane != 2'b00)));
    assign misaligned   = ~rst & misalign_hit;
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                req = mem_op & ~halt_q & ~misalign_hit;
                if (req & ~dmem.dmem_ready) state_d = WAIT;
            end
            WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ready) state_d = IDLE;
            end
        endcase
        // Reset must drop the request at once, even though IDLE would re-request combinationally.
        if (rst) req = 1'b0;
        stall   = req & ~dmem.dmem_ready;
        flush_d = (state_d == WAIT) & kill;
    end

    always_comb begin
        dmem.dmem_wdata = em_rdat2;
        dmem.dmem_strb  = 4'b1111;
        case (em_dwrite)
            2'd1: begin
                dmem.dmem_wdata = {4{em_rdat2[7:0]}};
                dmem.dmem_strb  = 4'b0001 << lane;
            end
            2'd2: begin
                dmem.dmem_wdata = {2{em_rdat2[15:0]}};
                dmem.dmem_strb  = 4'b0011 << {lane[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign dmem.dmem_req  = req;
    assign dmem.dmem_wen  = (em_dwrite != 2'd0);
    assign dmem.dmem_addr = {em_alu_out[WORD_W-1:2], 2'b00};
    assign mem_stall      = stall;

    always_comb begin
        pc_plus4   = em_pc + word_t'(4);
        taken      = ((em_pc_ctrl == 2'd1) & (em_alu_zero ^ em_branch_pol)) | em_pc_ctrl[1];
        target     = (em_pc_ctrl == 2'd3) ? {em_alu_out[WORD_W-1:1], 1'b0} : em_pc_plus_imm;
        mispredict = (em_branch_predict != taken) |
                     (em_branch_predict & taken & (em_branch_target != target));
        resolve_en = ~rst & (state_q == IDLE) & ~halt_q & ~stall;
        redirect    = resolve_en & ~kill & mispredict;
        redirect_pc = taken ? target : pc_plus4;
        bp_update   = resolve_en & (em_pc_ctrl != 2'd0);
        bp_taken    = taken;
        bp_target   = target;
    end

    always_comb begin
        wb_valid_d = (em_rd != '0) & ~kill & ~halt_q & ~misalign_hit;
        case (em_reg_wr_src)
            2'd1:    wb_data_d = dmem.dmem_rdata;
            2'd2:    wb_data_d = pc_plus4;
            default: wb_data_d = em_alu_out;
        endcase
        halt_d = halt_q | (em_halt & ~stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            flush_q    <= 1'b0;
            halt_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            halt_q  <= halt_d;
            if (!stall) begin
                wb_valid_q <= wb_valid_d;
                wb_rd_q    <= em_rd;
                wb_data_q  <= wb_data_d;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign halt     = halt_q;
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Consumer end of the execute-to-memory pipeline latch. Reads the latched EX/MEM fields and drives the data-memory bus through a request/ready handshake. It also resolves branches and jumps, checks the branch prediction and issues front-end redirects. It registers the MEM/WB result and holds the pipeline with a stall while a data access is outstanding.

Parameters:
WORD_W, 32, data/address width (word_t)
REG_W, 5, register index width (reg_t)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
em_pc  in  32  latched PC
em_halt  in  1  halt instruction
em_rd  in  5  destination register
em_dread  in  1  word load
em_dwrite  in  2  store size: 0 none, 1 byte, 2 half, 3 word
em_reg_wr_src  in  2  0 alu, 1 memory, 2 pc+4
em_branch_pol  in  1  0 taken if alu_zero=1; 1 taken if alu_zero=0
em_pc_ctrl  in  2  0 inc, 1 branch, 2 JAL, 3 JALR
em_rdat2  in  32  store data
em_alu_out  in  32  address / ALU result
em_alu_zero  in  1  ALU zero flag
em_pc_plus_imm  in  32  branch/JAL target
em_branch_predict  in  1  fetch predicted taken
em_branch_target  in  32  fetch predicted target
mem_flush  in  1  discard current instruction (kill wb result)
dmem_req  out  1  data bus request
dmem_wen  out  1  1 = store
dmem_addr  out  32  word-aligned address (alu_out & ~3)
dmem_wdata  out  32  lane-shifted store data
dmem_strb  out  4  byte enables
dmem_ready  in  1  bus completes this cycle
dmem_rdata  in  32  load data, valid with ready
mem_stall  out  1  hold upstream latches
redirect  out  1  mispredict; flush IF/ID/EX
redirect_pc  out  32  correct next PC
bp_update  out  1  branch-unit training strobe
bp_taken  out  1  resolved direction
bp_target  out  32  resolved target
wb_valid  out  1  registered: result valid
wb_rd  out  5  registered destination
wb_data  out  32  registered writeback data
halt  out  1  sticky halt

Behaviour:
- Reset (async, active-high): state IDLE. dmem_req, mem_stall, redirect, bp_update, wb_valid and halt are 0. wb_rd and wb_data are 0. Reset asserted mid-access drops dmem_req immediately.
- A memory op is em_dread=1 or em_dwrite!=0. A bubble is a no-op with rd=0 and pc_ctrl=0.
- FSM IDLE:
  - Memory op present and not halted: dmem_req=1 combinationally.
  - dmem_ready=1 the same cycle: access completes, no stall.
  - dmem_ready=0: go to WAIT, mem_stall=1.
- FSM WAIT:
  - dmem_req, addr, wdata, strb and wen are held stable; mem_stall=1.
  - On dmem_ready=1: complete, mem_stall=0, return to IDLE.
- Back-to-back memory ops with ready=1 every cycle issue one access per cycle.
- Stores: lane = alu_out[1:0].
  - Byte: wdata = rdat2[7:0] replicated to all lanes; strb = 1<<lane.
  - Half: halfword replicated; strb = 4'b0011<<{lane[1],1'b0}.
  - Word: strb = 4'b1111.
  - Loads drive strb=4'b1111 and wen=0.
- Branch resolution (combinational, IDLE only, never while stalled):
  - taken = (pc_ctrl==1 & (alu_zero^branch_pol)) | pc_ctrl>=2.
  - Target: pc_plus_imm for pc_ctrl 1 and 2; {alu_out[31:1],1'b0} for JALR.
  - redirect=1 if predict!=taken, or (predict & taken & branch_target!=target).
  - redirect_pc = taken ? target : pc+4.
  - bp_update=1 for any pc_ctrl!=0.
- Writeback register: updates on each edge where mem_stall=0. wb_valid=1 if rd!=0 and not mem_flush.
  - wb_data by reg_wr_src: alu_out (0), dmem_rdata (1), pc+4 (2).
- mem_flush takes effect only when the access is complete. An in-flight bus access always finishes; its result is discarded (wb_valid=0) and redirect is suppressed.
- Halt: em_halt with no stall sets halt the next edge; halt is sticky until reset.
  - When halted: no dmem_req, no redirect, no bp_update, wb_valid=0.
- All PC arithmetic is modulo 2^32 (pc+4 wraps 0xFFFFFFFC -> 0).

Optional Feature:
MEM_MISALIGN_CHECK_EN.
- Defined: adds output misaligned (1 bit). A half access with alu_out[0]=1, or a word access with alu_out[1:0]!=0, suppresses dmem_req, does not stall, asserts misaligned for that cycle and forces wb_valid=0.
- Undefined: no port. Address low bits are ignored for loads and used only for lane selection on stores.

Test Plan:
- Word load, alu_out=0x104, rd=5, reg_wr_src=1; ready low 2 cycles, then high with rdata 0xDEADBEEF -> mem_stall high 2 cycles, dmem_addr held 0x104, next edge wb_rd=5 and wb_data=0xDEADBEEF.
- Byte store, alu_out=0x103, rdat2=0x000000AB, ready=1 -> wdata=0xABABABAB, strb=4'b1000, wen=1, no stall.
- Branch: pc_ctrl=1, alu_zero=1, pol=0, predict=0, pc_plus_imm=0x200 -> redirect=1, redirect_pc=0x200, bp_taken=1.
- JALR: alu_out=0x301, predict=1, branch_target=0x300, pc=0x40, reg_wr_src=2, rd=1 -> redirect=0, bp_target=0x300, wb_data=0x44.
- Reset asserted in WAIT -> dmem_req=0 and mem_stall=0 asynchronously, wb_valid=0; after release a fresh load issues normally.
- em_halt=1 then a store -> halt=1 from the next edge, store never asserts dmem_req, halt stays 1 until rst.
